// File: rtl/letter_board_pkg.sv
// Shared constants and enums for the letter board: blank glyph code, keystroke kinds and FSM states.
package letter_board_pkg;

    localparam logic [4:0] BLANK = 5'd26;

    typedef enum logic [1:0] {
        LETTER    = 2'd0,
        BACKSPACE = 2'd1,
        ENTER     = 2'd2
    } key_type_e;

    typedef enum logic [1:0] {
        TYPING = 2'd0,
        COMMIT = 2'd1,
        FULL   = 2'd2
    } state_e;

    // Left/top pixel of cell idx along one axis, truncated to the 11-bit raster width.
    function automatic logic [10:0] cell_origin(input int base, input int idx,
                                                input int size, input int gap);
        return 11'(base + idx * (size + gap));
    endfunction

endpackage

// File: rtl/letter_board_cell_locator.sv
// Maps a raster position to a grid cell by compare chains; the cell index is combinational,
// the delayed raster position and the cell origin are registered.
module cell_locator
    import letter_board_pkg::*;
#(
    parameter int ROWS     = 6,
    parameter int COLS     = 5,
    parameter int CELL_W   = 38,
    parameter int CELL_H   = 45,
    parameter int GAP      = 4,
    parameter int ORIGIN_X = 100,
    parameter int ORIGIN_Y = 50
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        cell_hit_out,
    output logic [2:0]  cell_row_out,
    output logic [3:0]  cell_col_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [10:0] sprite_x_out,
    output logic [9:0]  sprite_y_out
);

    logic        col_hit;
    logic        row_hit;
    logic [10:0] x_org;
    logic [9:0]  y_org;
    logic [10:0] hcount_q;
    logic [9:0]  vcount_q;
    logic [10:0] sprite_x_q;
    logic [9:0]  sprite_y_q;
    logic [10:0] sprite_x_d;
    logic [9:0]  sprite_y_d;

    always_comb begin
        col_hit      = 1'b0;
        cell_col_out = '0;
        x_org        = '0;
        for (int c = 0; c < COLS; c++) begin
            if (hcount_in >= cell_origin(ORIGIN_X, c, CELL_W, GAP) &&
                hcount_in <= 11'(cell_origin(ORIGIN_X, c, CELL_W, GAP) + 11'(CELL_W - 1))) begin
                col_hit      = 1'b1;
                cell_col_out = 4'(c);
                x_org        = cell_origin(ORIGIN_X, c, CELL_W, GAP);
            end
        end
    end

    // Vertical chain is evaluated at 11 bits then narrowed; the grid is known to fit in 768 lines.
    always_comb begin
        row_hit      = 1'b0;
        cell_row_out = '0;
        y_org        = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ({1'b0, vcount_in} >= cell_origin(ORIGIN_Y, r, CELL_H, GAP) &&
                {1'b0, vcount_in} <= 11'(cell_origin(ORIGIN_Y, r, CELL_H, GAP) + 11'(CELL_H - 1))) begin
                row_hit      = 1'b1;
                cell_row_out = 3'(r);
                y_org        = 10'(cell_origin(ORIGIN_Y, r, CELL_H, GAP));
            end
        end
    end

    assign cell_hit_out = col_hit && row_hit;
    assign sprite_x_d   = cell_hit_out ? x_org : 11'd0;
    assign sprite_y_d   = cell_hit_out ? y_org : 10'd0;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            sprite_x_q <= '0;
            sprite_y_q <= '0;
        end else begin
            hcount_q   <= hcount_in;
            vcount_q   <= vcount_in;
            sprite_x_q <= sprite_x_d;
            sprite_y_q <= sprite_y_d;
        end
    end

    assign hcount_out   = hcount_q;
    assign vcount_out   = vcount_q;
    assign sprite_x_out = sprite_x_q;
    assign sprite_y_out = sprite_y_q;

endmodule

// File: rtl/letter_board.sv
// Word-game letter board: keystroke FSM editing a ROWS x COLS grid of letter codes,
// with a one-cycle raster path that reports which glyph to draw at each pixel.
module letter_board
    import letter_board_pkg::*;
#(
    parameter int ROWS     = 6,
    parameter int COLS     = 5,
    parameter int CELL_W   = 38,
    parameter int CELL_H   = 45,
    parameter int GAP      = 4,
    parameter int ORIGIN_X = 100,
    parameter int ORIGIN_Y = 50
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              key_valid_in,
    output logic              key_ready_out,
    input  logic [1:0]        key_type_in,
    input  logic [4:0]        key_letter_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    output logic [10:0]       hcount_out,
    output logic [9:0]        vcount_out,
    output logic [10:0]       sprite_x_out,
    output logic [9:0]        sprite_y_out,
    output logic [4:0]        letter_out,
    output logic              word_valid_out,
    output logic [5*COLS-1:0] word_out,
    output logic [2:0]        row_out,
    output logic              board_full_out,
    output logic [1:0]        state_out
);

    localparam logic [3:0] COLS_L   = 4'(COLS);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_e            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic [4:0]        grid_q [ROWS][COLS];
    logic [4:0]        grid_d [ROWS][COLS];
    logic [5*COLS-1:0] word_q, word_d;
    logic [4:0]        letter_q, letter_d;
    logic              key_accept;

    logic              loc_hit;
    logic [2:0]        loc_row;
    logic [3:0]        loc_col;

    // Handshake: a keystroke is consumed on a clock edge where key_valid_in and key_ready_out
    // are both high; ready is only offered in TYPING and never while reset is held.
    // Gating the pulse with rst_in also cancels a COMMIT that is interrupted by reset.
    assign key_ready_out  = rst_in && (state_q == TYPING);
    assign word_valid_out = rst_in && (state_q == COMMIT);
    assign board_full_out = (state_q == FULL);
    assign key_accept     = key_valid_in && key_ready_out;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        grid_d  = grid_q;
        word_d  = word_q;
        case (state_q)
            TYPING: begin
                if (key_accept) begin
                    case (key_type_in)
                        LETTER: begin
                            if (col_q < COLS_L) begin
                                for (int r = 0; r < ROWS; r++)
                                    for (int c = 0; c < COLS; c++)
                                        if (3'(r) == row_q && 4'(c) == col_q)
                                            grid_d[r][c] = key_letter_in;
                                col_d = col_q + 4'd1;
                            end
                        end
                        BACKSPACE: begin
                            if (col_q != 4'd0) begin
                                col_d = col_q - 4'd1;
                                for (int r = 0; r < ROWS; r++)
                                    for (int c = 0; c < COLS; c++)
                                        if (3'(r) == row_q && 4'(c) == col_d)
                                            grid_d[r][c] = BLANK;
                            end
                        end
                        ENTER: begin
                            if (col_q == COLS_L) begin
                                for (int r = 0; r < ROWS; r++)
                                    if (3'(r) == row_q)
                                        for (int c = 0; c < COLS; c++)
                                            word_d[c*5 +: 5] = grid_q[r][c];
                                state_d = COMMIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            COMMIT: begin
                if (row_q == LAST_ROW) begin
                    state_d = FULL;
                end else begin
                    row_d   = row_q + 3'd1;
                    col_d   = 4'd0;
                    state_d = TYPING;
                end
            end
            FULL:    state_d = FULL;
            default: state_d = TYPING;
        endcase
    end

    // Reads the pre-edge grid, so a cell written on this edge shows from the next one.
    always_comb begin
        letter_d = BLANK;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (loc_hit && loc_row == 3'(r) && loc_col == 4'(c))
                    letter_d = grid_q[r][c];
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            state_q  <= TYPING;
            row_q    <= '0;
            col_q    <= '0;
            word_q   <= '0;
            letter_q <= BLANK;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    grid_q[r][c] <= BLANK;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            word_q   <= word_d;
            letter_q <= letter_d;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    grid_q[r][c] <= grid_d[r][c];
        end
    end

    cell_locator #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .CELL_W   (CELL_W),
        .CELL_H   (CELL_H),
        .GAP      (GAP),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y)
    ) u_locator (
        .clk_in       (pixel_clk_in),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .cell_hit_out (loc_hit),
        .cell_row_out (loc_row),
        .cell_col_out (loc_col),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out),
        .sprite_x_out (sprite_x_out),
        .sprite_y_out (sprite_y_out)
    );

    assign letter_out = letter_q;
    assign word_out   = word_q;
    assign row_out    = row_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_letter_board.sv
// Directed bench for letter_board: keystroke editing, commits, board-full lockout,
// raster lookups and reset during a commit.
module tb_letter_board;
    import letter_board_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [1:0]  key_type = 2'd0;
    logic [4:0]  key_letter = 5'd0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic [10:0] hcount_o;
    logic [9:0]  vcount_o;
    logic [10:0] sprite_x;
    logic [9:0]  sprite_y;
    logic [4:0]  letter;
    logic        word_valid;
    logic [24:0] word;
    logic [2:0]  row;
    logic        board_full;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    letter_board dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .key_valid_in   (key_valid),
        .key_ready_out  (key_ready),
        .key_type_in    (key_type),
        .key_letter_in  (key_letter),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .hcount_out     (hcount_o),
        .vcount_out     (vcount_o),
        .sprite_x_out   (sprite_x),
        .sprite_y_out   (sprite_y),
        .letter_out     (letter),
        .word_valid_out (word_valid),
        .word_out       (word),
        .row_out        (row),
        .board_full_out (board_full),
        .state_out      (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offers one keystroke for exactly one rising edge; returns at the following falling edge.
    task automatic key(input logic [1:0] t, input logic [4:0] l);
        @(negedge clk);
        key_valid  = 1'b1;
        key_type   = t;
        key_letter = l;
        @(negedge clk);
        key_valid  = 1'b0;
    endtask

    task automatic type5(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [4:0] d, input logic [4:0] e);
        key(2'd0, a); key(2'd0, b); key(2'd0, c); key(2'd0, d); key(2'd0, e);
    endtask

    task automatic probe(input int h, input int v);
        @(negedge clk);
        hcount = 11'(h);
        vcount = 10'(v);
        @(negedge clk);
    endtask

    function automatic int cx(input int c);
        return 100 + 42 * c;
    endfunction

    function automatic int cy(input int r);
        return 50 + 49 * r;
    endfunction

    initial begin
        // reset with the raster parked on cell (0,0)
        hcount = 11'd100;
        vcount = 10'd50;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(key_ready), 32'd0);
        chk("rst_wvalid", 32'(word_valid), 32'd0);
        chk("rst_full", 32'(board_full), 32'd0);
        chk("rst_word", 32'(word), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_letter", 32'(letter), 32'd26);
        chk("rst_sx", 32'(sprite_x), 32'd0);
        chk("rst_sy", 32'(sprite_y), 32'd0);
        chk("rst_hcnt", 32'(hcount_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(key_ready), 32'd1);
        probe(cx(0), cy(0));
        chk("blank00", 32'(letter), 32'd26);
        chk("org00_x", 32'(sprite_x), 32'd100);

        // type A,B then three backspaces: no underflow, cells cleared
        key(2'd0, 5'd0);
        key(2'd0, 5'd1);
        probe(cx(1), cy(0));
        chk("cell01_B", 32'(letter), 32'd1);
        key(2'd1, 5'd0); key(2'd1, 5'd0); key(2'd1, 5'd0);
        probe(cx(0), cy(0));
        chk("bs_cell00", 32'(letter), 32'd26);
        probe(cx(1), cy(0));
        chk("bs_cell01", 32'(letter), 32'd26);

        // col back at 0: next letter lands in cell (0,0)
        key(2'd0, 5'd7);
        probe(100, 50);
        chk("sweep_letter", 32'(letter), 32'd7);
        chk("sweep_sx", 32'(sprite_x), 32'd100);
        chk("sweep_sy", 32'(sprite_y), 32'd50);
        probe(138, 50);
        chk("gap_letter", 32'(letter), 32'd26);
        chk("gap_sx", 32'(sprite_x), 32'd0);
        chk("gap_sy", 32'(sprite_y), 32'd0);
        probe(142, 60);
        chk("c1_sx", 32'(sprite_x), 32'd142);
        chk("c1_sy", 32'(sprite_y), 32'd50);
        chk("c1_hout", 32'(hcount_o), 32'd142);
        chk("c1_vout", 32'(vcount_o), 32'd60);
        probe(cx(0), 95);
        chk("vgap_letter", 32'(letter), 32'd26);
        key(2'd1, 5'd0);

        // CRANE + ENTER
        type5(5'd2, 5'd17, 5'd0, 5'd13, 5'd4);
        key(2'd2, 5'd0);
        chk("crane_pulse", 32'(word_valid), 32'd1);
        chk("crane_ready", 32'(key_ready), 32'd0);
        chk("crane_word", 32'(word), 32'({5'd4, 5'd13, 5'd0, 5'd17, 5'd2}));
        @(negedge clk);
        chk("crane_pulse_end", 32'(word_valid), 32'd0);
        chk("crane_row", 32'(row), 32'd1);
        chk("crane_ready2", 32'(key_ready), 32'd1);
        probe(cx(4), cy(0));
        chk("cell04_E", 32'(letter), 32'd4);

        // six letters in row 1: sixth dropped
        type5(5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
        key(2'd0, 5'd5);
        probe(cx(4), cy(1));
        chk("cell14_keep", 32'(letter), 32'd4);
        key(2'd2, 5'd0);
        chk("row1_word", 32'(word), 32'({5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));
        @(negedge clk);
        chk("row1_next", 32'(row), 32'd2);

        // short ENTER in row 2 ignored
        key(2'd0, 5'd10); key(2'd0, 5'd11); key(2'd0, 5'd12); key(2'd0, 5'd13);
        key(2'd2, 5'd0);
        chk("short_pulse", 32'(word_valid), 32'd0);
        chk("short_ready", 32'(key_ready), 32'd1);
        @(negedge clk);
        chk("short_word", 32'(word), 32'({5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));
        chk("short_row", 32'(row), 32'd2);
        key(2'd0, 5'd14);
        key(2'd2, 5'd0);
        chk("row2_word", 32'(word), 32'({5'd14, 5'd13, 5'd12, 5'd11, 5'd10}));
        @(negedge clk);

        // unknown key kind consumed and ignored
        key(2'd3, 5'd9);
        chk("unk_ready", 32'(key_ready), 32'd1);
        probe(cx(0), cy(3));
        chk("unk_cell30", 32'(letter), 32'd26);

        // rows 3..5 fill the board
        type5(5'd15, 5'd16, 5'd17, 5'd18, 5'd19);
        key(2'd2, 5'd0);
        @(negedge clk);
        type5(5'd20, 5'd21, 5'd22, 5'd23, 5'd24);
        key(2'd2, 5'd0);
        @(negedge clk);
        chk("row5", 32'(row), 32'd5);
        type5(5'd25, 5'd24, 5'd23, 5'd22, 5'd21);
        key(2'd2, 5'd0);
        chk("last_pulse", 32'(word_valid), 32'd1);
        chk("last_word", 32'(word), 32'({5'd21, 5'd22, 5'd23, 5'd24, 5'd25}));
        @(negedge clk);
        chk("full_flag", 32'(board_full), 32'd1);
        chk("full_ready", 32'(key_ready), 32'd0);
        chk("full_row", 32'(row), 32'd5);
        key(2'd1, 5'd0);
        key(2'd2, 5'd0);
        chk("full_nopulse", 32'(word_valid), 32'd0);
        chk("full_stays", 32'(board_full), 32'd1);
        probe(cx(4), cy(5));
        chk("full_cell54", 32'(letter), 32'd21);
        chk("full_sy", 32'(sprite_y), 32'd295);

        // reset during COMMIT cancels the pulse and clears the grid
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst2_full", 32'(board_full), 32'd0);
        type5(5'd3, 5'd3, 5'd3, 5'd3, 5'd3);
        key(2'd2, 5'd0);
        chk("pre_cancel_pulse", 32'(word_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("cancel_pulse", 32'(word_valid), 32'd0);
        chk("cancel_ready", 32'(key_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_ready", 32'(key_ready), 32'd1);
        @(negedge clk);
        chk("post_pulse", 32'(word_valid), 32'd0);
        chk("post_row", 32'(row), 32'd0);
        chk("post_word", 32'(word), 32'd0);
        probe(cx(0), cy(0));
        chk("post_cell00", 32'(letter), 32'd26);
        probe(cx(4), cy(0));
        chk("post_cell04", 32'(letter), 32'd26);
        probe(cx(4), cy(5));
        chk("post_cell54", 32'(letter), 32'd26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
